// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI responder block.
package spi_pkg;

    localparam int SPI_MAXLEN_DEF = 16;

    typedef enum logic [1:0] {
        ARM_WAIT = 2'd0,
        IDLE     = 2'd1,
        ACTIVE   = 2'd2
    } spi_rsp_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall pulses
// derived from the synchronized level.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~dly_q;
    assign fall  = ~level & dly_q;

endmodule

// File: rtl/spi_slave_rsp.sv
// SPI mode-0 responder: oversampled pins, MSB-first shift in/out, tx shadow
// register and a one-cycle rx pulse per completed frame.
module spi_slave_rsp
    import spi_pkg::*;
#(
    parameter int SPI_MAXLEN  = SPI_MAXLEN_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          SCLK,
    input  logic                          SS_N,
    input  logic                          MOSI,
    output logic                          MISO,
    output logic                          MISO_OE,
    input  logic [SPI_MAXLEN-1:0]         tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [SPI_MAXLEN-1:0]         rx_data,
    output logic [$clog2(SPI_MAXLEN):0]   rx_nbits,
    output logic                          rx_valid,
    output logic                          rx_overflow,
    output logic                          tx_underrun
);

    localparam int CW = $clog2(SPI_MAXLEN) + 1;
    localparam int AW = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] CNT_MAX  = CW'(SPI_MAXLEN);
    localparam logic [AW-1:0] ARM_LAST = AW'(SYNC_STAGES + 1);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic ss_level, ss_rise, ss_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic mosi_edges_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .din(SCLK),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .reset(reset), .din(SS_N),
        .level(ss_level), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .din(MOSI),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign mosi_edges_unused = mosi_rise ^ mosi_fall;

    spi_rsp_state_t state, state_n;

    logic [AW-1:0]         arm_cnt;
    logic                  arm_done;
    logic [SPI_MAXLEN-1:0] shadow, tx_shift, rx_shift, rx_shift_n;
    logic                  shadow_full;
    logic [CW-1:0]         bit_cnt, cnt_n;
    logic                  ovf_pend, ovf_n, und_pend;
    logic                  miso_q;
    logic                  tx_wr, frame_start;

    // The synchronizer flops come out of reset at idle levels, so the
    // chain must be refilled from the pins before SS_N can be trusted.
    assign arm_done = (arm_cnt == ARM_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ARM_WAIT;
            arm_cnt <= '0;
        end else begin
            state <= state_n;
            if (state == ARM_WAIT && !arm_done)
                arm_cnt <= arm_cnt + AW'(1);
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ARM_WAIT: if (arm_done && ss_level) state_n = IDLE;
            IDLE:     if (ss_fall)              state_n = ACTIVE;
            ACTIVE:   if (ss_rise)              state_n = IDLE;
            default:                            state_n = ARM_WAIT;
        endcase
    end

    // Next rx state for this cycle; the frame-end path reuses it so a
    // final SCLK rise coincident with SS_N rise is still counted.
    always_comb begin
        rx_shift_n = rx_shift;
        cnt_n      = bit_cnt;
        ovf_n      = ovf_pend;
        if (state == ACTIVE && sclk_rise) begin
            rx_shift_n = {rx_shift[SPI_MAXLEN-2:0], mosi_level};
            if (bit_cnt == CNT_MAX) ovf_n = 1'b1;
            else                    cnt_n = bit_cnt + CW'(1);
        end
    end

    assign tx_wr       = tx_valid && !shadow_full;
    assign frame_start = (state == IDLE) && ss_fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow      <= '0;
            shadow_full <= 1'b0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            ovf_pend    <= 1'b0;
            und_pend    <= 1'b0;
            miso_q      <= 1'b0;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            rx_nbits    <= '0;
            rx_overflow <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            // A write landing with SS_N fall misses this frame's load.
            if (tx_wr) begin
                shadow      <= tx_data;
                shadow_full <= 1'b1;
            end else if (frame_start && shadow_full) begin
                shadow_full <= 1'b0;
            end

            if (frame_start) begin
                tx_shift <= shadow_full ? shadow : '0;
                und_pend <= !shadow_full;
                miso_q   <= shadow_full & shadow[SPI_MAXLEN-1];
                bit_cnt  <= '0;
                rx_shift <= '0;
                ovf_pend <= 1'b0;
            end else if (state == ACTIVE) begin
                rx_shift <= rx_shift_n;
                bit_cnt  <= cnt_n;
                ovf_pend <= ovf_n;
                if (sclk_fall) begin
                    tx_shift <= tx_shift << 1;
                    miso_q   <= tx_shift[SPI_MAXLEN-2];
                end
                if (ss_rise) begin
                    miso_q   <= 1'b0;
                    ovf_pend <= 1'b0;
                    und_pend <= 1'b0;
                    if (cnt_n != '0) begin
                        rx_valid    <= 1'b1;
                        rx_data     <= rx_shift_n;
                        rx_nbits    <= cnt_n;
                        rx_overflow <= ovf_n;
                        tx_underrun <= und_pend;
                    end
                end
            end
        end
    end

    assign MISO     = miso_q;
    assign MISO_OE  = (state == ACTIVE);
    assign tx_ready = !shadow_full;

endmodule

// File: tb/tb_spi_slave_rsp.sv
// Directed bench for spi_slave_rsp: SPI master model drives frames, a
// scoreboard queue holds expected rx results popped by a monitor on rx_valid.
module tb_spi_slave_rsp;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset, SCLK, SS_N, MOSI;
    logic          MISO, MISO_OE;
    logic [W-1:0]  tx_data;
    logic          tx_valid, tx_ready;
    logic [W-1:0]  rx_data;
    logic [4:0]    rx_nbits;
    logic          rx_valid, rx_overflow, tx_underrun;

    typedef struct packed {
        logic [15:0] data;
        logic [4:0]  nbits;
        logic        ovf;
        logic        und;
    } rx_exp_t;

    rx_exp_t exp_q[$];
    int errors = 0;
    int checks = 0;

    spi_slave_rsp #(.SPI_MAXLEN(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .SCLK(SCLK), .SS_N(SS_N), .MOSI(MOSI),
        .MISO(MISO), .MISO_OE(MISO_OE),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_nbits(rx_nbits), .rx_valid(rx_valid),
        .rx_overflow(rx_overflow), .tx_underrun(tx_underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic expect_rx(input logic [15:0] d, input logic [4:0] n, input logic o, input logic u);
        rx_exp_t e;
        e.data = d; e.nbits = n; e.ovf = o; e.und = u;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        rx_exp_t e;
        if (rx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got rx_valid data=%0h nbits=%0d, required no rx_valid",
                         rx_data, rx_nbits);
            end else begin
                e = exp_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(e.data));
                check("rx_nbits", 32'(rx_nbits), 32'(e.nbits));
                check("rx_overflow", 32'(rx_overflow), 32'(e.ovf));
                check("tx_underrun", 32'(tx_underrun), 32'(e.und));
            end
        end
    end

    task automatic load(input logic [15:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_ready_drop", 32'(tx_ready), 32'd0);
    endtask

    task automatic sclk_pulse(input logic b);
        MOSI = b;
        #50 SCLK = 1'b1;
        #50 SCLK = 1'b0;
    endtask

    // MISO is sampled at each SCLK rise, the instant a mode-0 master samples.
    task automatic frame(input logic [31:0] mosi, input int n, input logic [31:0] exp_miso);
        logic [31:0] got;
        int oe_bad;
        got = '0;
        oe_bad = 0;
        @(negedge clk);
        SS_N = 1'b0;
        #100;
        for (int i = n - 1; i >= 0; i--) begin
            MOSI = mosi[i];
            #50;
            SCLK = 1'b1;
            got = {got[30:0], MISO};
            if (MISO_OE !== 1'b1) oe_bad++;
            #50 SCLK = 1'b0;
        end
        #100 SS_N = 1'b1;
        #300;
        check("miso_stream", got, exp_miso);
        check("miso_oe", 32'(oe_bad), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},     32'(MISO),     32'd0);
        check({tag, "_miso_oe"},  32'(MISO_OE),  32'd0);
        check({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_rx_data"},  32'(rx_data),  32'd0);
        check({tag, "_rx_nbits"}, 32'(rx_nbits), 32'd0);
    endtask

    initial begin
        reset = 1'b1; SCLK = 1'b0; SS_N = 1'b1; MOSI = 1'b0;
        tx_valid = 1'b0; tx_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // 1: 0x003C loaded, only its top byte (zero) goes out on an 8-bit frame
        load(16'h003C);
        expect_rx(16'h00A5, 5'd8, 1'b0, 1'b0);
        frame(32'hA5, 8, 32'h00);

        // 2: full 16-bit exchange
        load(16'hBEEF);
        expect_rx(16'h1234, 5'd16, 1'b0, 1'b0);
        frame(32'h1234, 16, 32'hBEEF);

        // 3: 20 bits keeps the last 16, overflow, MISO zero after the word
        load(16'hFFFF);
        expect_rx(16'hBCDE, 5'd16, 1'b1, 1'b0);
        frame(32'hABCDE, 20, 32'hFFFF0);

        // 4: no word loaded
        expect_rx(16'h005A, 5'd8, 1'b0, 1'b1);
        frame(32'h5A, 8, 32'h0);
        check("tx_ready_idle", 32'(tx_ready), 32'd1);

        // 5: short frame, then an SS_N pulse with no SCLK
        expect_rx(16'h0005, 5'd3, 1'b0, 1'b1);
        frame(32'h5, 3, 32'h0);
        frame(32'h0, 0, 32'h0);
        check("no_pending_rx", 32'(exp_q.size()), 32'd0);

        // 6: reset in the middle of a frame with SS_N held low
        @(negedge clk);
        SS_N = 1'b0;
        #100;
        repeat (3) sclk_pulse(1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b0;
        repeat (4) sclk_pulse(1'b0);
        #100 SS_N = 1'b1;
        #300;
        check("post_reset_oe", 32'(MISO_OE), 32'd0);
        load(16'hA500);
        expect_rx(16'h003C, 5'd8, 1'b0, 1'b0);
        frame(32'h3C, 8, 32'hA5);

        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
